// File: rtl/sequencer.sv
// sequencer: control FSM for a simple accumulator CPU.
// Drives the bus-enable and register-load strobes for the fetch, decode,
// memory-read, execute and store phases of each instruction.
//
// Ports:
//   clock, reset         rising-edge clock; asynchronous active-high reset
//   op[OP_W-1:0]         opcode from IR (looked at in DECODE and EXEC only)
//   z_flag               accumulator-zero flag (decides BNE in DECODE)
//   PC_bus, load_PC, INC_PC                  program counter controls
//   load_IR, Addr_bus                        instruction register controls
//   load_MAR, CS, R_NW, MDR_bus, load_MDR    memory controls (R_NW: 1=read)
//   ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub  accumulator/ALU controls
//   instr_done           one-cycle pulse in the last state of each instruction
module sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            CS,
  output logic            R_NW,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            instr_done
);

  typedef enum logic [2:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_RD,     S_EXEC,   S_ST0,    S_ST1
  } state_t;

  state_t r_state;

  logic w_is_load, w_is_store, w_is_add, w_is_sub, w_is_bne, w_is_mem_rd;

  assign w_is_load   = (op == OP_W'(0));
  assign w_is_store  = (op == OP_W'(1));
  assign w_is_add    = (op == OP_W'(2));
  assign w_is_sub    = (op == OP_W'(3));
  assign w_is_bne    = (op == OP_W'(4));
  assign w_is_mem_rd = w_is_load | w_is_add | w_is_sub;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH0;
    end else begin
      case (r_state)
        S_FETCH0: r_state <= S_FETCH1;
        S_FETCH1: r_state <= S_FETCH2;
        S_FETCH2: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_mem_rd)     r_state <= S_RD;
          else if (w_is_store) r_state <= S_ST0;
          else                 r_state <= S_FETCH0;
        end
        S_RD:     r_state <= S_EXEC;
        S_EXEC:   r_state <= S_FETCH0;
        S_ST0:    r_state <= S_ST1;
        S_ST1:    r_state <= S_FETCH0;
        default:  r_state <= S_FETCH0;
      endcase
    end
  end

  // Strobes are decoded from the current state (plus op/z_flag in DECODE
  // and EXEC) and gated by reset itself, so an asserted reset drops CS and
  // restores R_NW without waiting for the state register to clear.
  always_comb begin
    PC_bus     = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    load_IR    = 1'b0;
    Addr_bus   = 1'b0;
    load_MAR   = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b1;
    MDR_bus    = 1'b0;
    load_MDR   = 1'b0;
    ACC_bus    = 1'b0;
    load_ACC   = 1'b0;
    ALU_ACC    = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH0: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
          load_PC  = 1'b1;
        end
        S_FETCH1: CS = 1'b1;
        S_FETCH2: begin
          MDR_bus = 1'b1;
          load_IR = 1'b1;
        end
        S_DECODE: begin
          if (w_is_mem_rd || w_is_store) begin
            Addr_bus = 1'b1;
            load_MAR = 1'b1;
          end else begin
            instr_done = 1'b1;
            if (w_is_bne && !z_flag) begin
              Addr_bus = 1'b1;
              load_PC  = 1'b1;
            end
          end
        end
        S_RD: CS = 1'b1;
        S_EXEC: begin
          MDR_bus    = 1'b1;
          load_ACC   = 1'b1;
          instr_done = 1'b1;
          if (w_is_add) begin
            ALU_ACC = 1'b1;
            ALU_add = 1'b1;
          end else if (w_is_sub) begin
            ALU_ACC = 1'b1;
            ALU_sub = 1'b1;
          end
        end
        S_ST0: begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
        end
        S_ST1: begin
          CS         = 1'b1;
          R_NW       = 1'b0;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// tb_sequencer: self-checking bench for the sequencer control FSM.
// Directed table of instructions, randomized instruction stream against an
// instruction-level expansion model, and asynchronous reset aborts.
module tb_sequencer;

  localparam logic [15:0] B_PCBUS  = 16'h8000;
  localparam logic [15:0] B_LDPC   = 16'h4000;
  localparam logic [15:0] B_INC    = 16'h2000;
  localparam logic [15:0] B_LDIR   = 16'h1000;
  localparam logic [15:0] B_ADDR   = 16'h0800;
  localparam logic [15:0] B_LDMAR  = 16'h0400;
  localparam logic [15:0] B_CS     = 16'h0200;
  localparam logic [15:0] B_RNW    = 16'h0100;
  localparam logic [15:0] B_MDRBUS = 16'h0080;
  localparam logic [15:0] B_LDMDR  = 16'h0040;
  localparam logic [15:0] B_ACCBUS = 16'h0020;
  localparam logic [15:0] B_LDACC  = 16'h0010;
  localparam logic [15:0] B_ALUACC = 16'h0008;
  localparam logic [15:0] B_ADD    = 16'h0004;
  localparam logic [15:0] B_SUB    = 16'h0002;
  localparam logic [15:0] B_DONE   = 16'h0001;

  localparam logic [15:0] V_F0 = B_RNW | B_PCBUS | B_LDMAR | B_INC | B_LDPC;
  localparam logic [15:0] V_F1 = B_RNW | B_CS;
  localparam logic [15:0] V_F2 = B_RNW | B_MDRBUS | B_LDIR;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] op = 3'd0;
  logic       z_flag = 1'b0;
  logic PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, CS, R_NW;
  logic MDR_bus, load_MDR, ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, instr_done;
  logic [15:0] act;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_q[$];

  sequencer #(.OP_W(3)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag),
    .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR),
    .Addr_bus(Addr_bus), .load_MAR(load_MAR), .CS(CS), .R_NW(R_NW),
    .MDR_bus(MDR_bus), .load_MDR(load_MDR), .ACC_bus(ACC_bus),
    .load_ACC(load_ACC), .ALU_ACC(ALU_ACC), .ALU_add(ALU_add),
    .ALU_sub(ALU_sub), .instr_done(instr_done)
  );

  assign act = {PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, CS, R_NW,
                MDR_bus, load_MDR, ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub,
                instr_done};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end
  endtask

  // Structural rules that must hold in every cycle.
  task automatic check_invariants(input string name);
    n_cmp++;
    if ((ALU_add && ALU_sub) ||
        ($countones({ACC_bus, PC_bus, Addr_bus, MDR_bus}) > 1)) begin
      n_bad++;
      $display("FAIL %s-invariant: add=%b sub=%b buses=%b required add&sub=0, buses one-hot-or-zero",
               name, ALU_add, ALU_sub, {ACC_bus, PC_bus, Addr_bus, MDR_bus});
    end
  endtask

  // Instruction-level model: an instruction is a 3-cycle fetch followed by
  // a class-dependent tail (memory read + execute, store, or decode-only).
  task automatic expand(input logic [2:0] o, input logic z);
    exp_q.delete();
    exp_q.push_back(V_F0);
    exp_q.push_back(V_F1);
    exp_q.push_back(V_F2);
    if (o == 3'd0 || o == 3'd2 || o == 3'd3) begin
      exp_q.push_back(B_RNW | B_ADDR | B_LDMAR);
      exp_q.push_back(B_RNW | B_CS);
      exp_q.push_back(B_RNW | B_MDRBUS | B_LDACC | B_DONE |
                      ((o == 3'd2) ? (B_ALUACC | B_ADD) : 16'h0) |
                      ((o == 3'd3) ? (B_ALUACC | B_SUB) : 16'h0));
    end else if (o == 3'd1) begin
      exp_q.push_back(B_RNW | B_ADDR | B_LDMAR);
      exp_q.push_back(B_RNW | B_ACCBUS | B_LDMDR);
      exp_q.push_back(B_CS | B_DONE);
    end else if (o == 3'd4) begin
      exp_q.push_back(B_RNW | B_DONE | (z ? 16'h0 : (B_ADDR | B_LDPC)));
    end else begin
      exp_q.push_back(B_RNW | B_DONE);
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later, wait for the
  // next falling edge (the rising edge advances the DUT in between).
  task automatic apply_cycle(input string name, input logic [2:0] o, input logic z,
                             input logic [15:0] want);
    op = o;
    z_flag = z;
    #1;
    check(name, act, want);
    check_invariants(name);
    @(negedge clock);
  endtask

  // Run one instruction against the model. With noise, op/z are scrambled
  // in every cycle where the sequencer must ignore them.
  task automatic run_instr(input string name, input logic [2:0] o, input logic z,
                           input bit noise);
    logic       mem_rd;
    logic [2:0] co;
    logic       cz;
    expand(o, z);
    mem_rd = (o == 3'd0 || o == 3'd2 || o == 3'd3);
    for (int c = 0; c < exp_q.size(); c++) begin
      co = o;
      cz = z;
      if (noise && c != 3) begin
        if (!(c == 5 && mem_rd)) co = 3'($urandom_range(0, 7));
        cz = 1'($urandom);
      end
      apply_cycle($sformatf("%s.c%0d", name, c), co, cz, exp_q[c]);
    end
  endtask

  // Assert reset asynchronously in the middle of cycle `at` of an instruction.
  task automatic reset_abort(input string name, input logic [2:0] o, input int unsigned at);
    expand(o, 1'b0);
    for (int unsigned c = 0; c < at; c++)
      apply_cycle($sformatf("%s.c%0d", name, c), o, 1'b0, exp_q[c]);
    op = o;
    z_flag = 1'b0;
    #1;
    check({name, "-pre"}, act, exp_q[at]);
    #1;
    reset = 1'b1;
    #1;
    check({name, "-abort"}, act, B_RNW);
    @(posedge clock);
    #1;
    check({name, "-hold"}, act, B_RNW);
    @(negedge clock);
    reset = 1'b0;
    run_instr({name, "-after"}, 3'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        z;
    int unsigned len;
    logic [15:0] v3;
    logic [15:0] v4;
    logic [15:0] v5;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [15:0] want;
    tbl[0] = '{"LOAD",  3'd0, 1'b0, 6, B_RNW|B_ADDR|B_LDMAR, B_RNW|B_CS,
               B_RNW|B_MDRBUS|B_LDACC|B_DONE};
    tbl[1] = '{"ADD",   3'd2, 1'b1, 6, B_RNW|B_ADDR|B_LDMAR, B_RNW|B_CS,
               B_RNW|B_MDRBUS|B_LDACC|B_ALUACC|B_ADD|B_DONE};
    tbl[2] = '{"SUB",   3'd3, 1'b0, 6, B_RNW|B_ADDR|B_LDMAR, B_RNW|B_CS,
               B_RNW|B_MDRBUS|B_LDACC|B_ALUACC|B_SUB|B_DONE};
    tbl[3] = '{"STORE", 3'd1, 1'b0, 6, B_RNW|B_ADDR|B_LDMAR, B_RNW|B_ACCBUS|B_LDMDR,
               B_CS|B_DONE};
    tbl[4] = '{"BNEz0", 3'd4, 1'b0, 4, B_RNW|B_ADDR|B_LDPC|B_DONE, 16'h0, 16'h0};
    tbl[5] = '{"BNEz1", 3'd4, 1'b1, 4, B_RNW|B_DONE, 16'h0, 16'h0};
    tbl[6] = '{"NOP5",  3'd5, 1'b0, 4, B_RNW|B_DONE, 16'h0, 16'h0};
    tbl[7] = '{"NOP6",  3'd6, 1'b1, 4, B_RNW|B_DONE, 16'h0, 16'h0};
    tbl[8] = '{"NOP7",  3'd7, 1'b0, 4, B_RNW|B_DONE, 16'h0, 16'h0};

    // Reset held: FETCH0 strobes are gated off.
    #1;
    check("reset-hold0", act, B_RNW);
    @(posedge clock);
    #1;
    check("reset-hold1", act, B_RNW);
    @(negedge clock);
    reset = 1'b0;

    // Directed table; first entry also checks FETCH0 right after release.
    for (int i = 0; i < 9; i++) begin
      for (int unsigned c = 0; c < tbl[i].len; c++) begin
        case (c)
          0: want = V_F0;
          1: want = V_F1;
          2: want = V_F2;
          3: want = tbl[i].v3;
          4: want = tbl[i].v4;
          default: want = tbl[i].v5;
        endcase
        apply_cycle($sformatf("tbl-%s.c%0d", tbl[i].name, c), tbl[i].op, tbl[i].z, want);
      end
    end

    // Randomized instruction stream with don't-care inputs scrambled.
    for (int i = 0; i < 60; i++)
      run_instr($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 1'($urandom), 1'b1);

    // Asynchronous aborts: mid-store at ST1, and during an ADD execute.
    reset_abort("abort-ST1", 3'd1, 5);
    reset_abort("abort-EXEC", 3'd2, 5);
    reset_abort("abort-FETCH1", 3'd3, 1);

    run_instr("final-BNE", 3'd4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter OP_W, default 3: opcode field width, the upper bits of the instruction word.
REQ-002 The port list SHALL be:
  clock  input  1  system clock; all state changes on its rising edge.
  reset  input  1  asynchronous, active-high reset.
  op  input  OP_W  opcode from IR; valid from DECODE onward.
  z_flag  input  1  accumulator-zero flag from ALU.
  PC_bus  output  1  PC drives sysbus.
  load_PC  output  1  PC loads from sysbus, or increments when INC_PC=1.
  INC_PC  output  1  PC increment select.
  load_IR  output  1  IR loads from sysbus.
  Addr_bus  output  1  IR address field drives sysbus.
  load_MAR  output  1  memory MAR loads from sysbus.
  CS  output  1  memory chip select.
  R_NW  output  1  1=read, 0=write.
  MDR_bus  output  1  memory MDR drives sysbus.
  load_MDR  output  1  memory MDR loads from sysbus.
  ACC_bus  output  1  ACC drives sysbus.
  load_ACC  output  1  ACC loads.
  ALU_ACC  output  1  1=ACC loads ALU result; 0=ACC loads sysbus directly.
  ALU_add  output  1  ALU adds.
  ALU_sub  output  1  ALU subtracts.
  instr_done  output  1  one-cycle pulse on the final state of each instruction.

Function
REQ-003 The opcodes SHALL be LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100; all other codes are NOP.
REQ-004 The sequencer SHALL be a Moore/Mealy FSM with states FETCH0, FETCH1, FETCH2, DECODE, RD, EXEC, ST0 and ST1; the outputs SHALL depend only on state, op and z_flag.
REQ-005 Any output not listed as active in a state SHALL be 0, except R_NW, which SHALL be 1.
REQ-006 FETCH0 SHALL assert PC_bus, load_MAR, INC_PC and load_PC, then go to FETCH1.
REQ-007 FETCH1 SHALL assert CS with R_NW=1, then go to FETCH2.
REQ-008 FETCH2 SHALL assert MDR_bus and load_IR, then go to DECODE.
REQ-009 DECODE with op = LOAD, ADD or SUB SHALL assert Addr_bus and load_MAR, then go to RD.
REQ-010 DECODE with op = STORE SHALL assert Addr_bus and load_MAR, then go to ST0.
REQ-011 DECODE with op = BNE and z_flag=0 SHALL assert Addr_bus and load_PC (INC_PC=0); with z_flag=1 it SHALL assert nothing; in both cases it SHALL pulse instr_done and go to FETCH0.
REQ-012 DECODE with a NOP opcode SHALL assert nothing, pulse instr_done and go to FETCH0.
REQ-013 RD SHALL assert CS with R_NW=1, then go to EXEC.
REQ-014 EXEC SHALL assert MDR_bus and load_ACC, plus:
  - LOAD: ALU_ACC=0.
  - ADD: ALU_ACC=1 and ALU_add=1.
  - SUB: ALU_ACC=1 and ALU_sub=1.
  EXEC SHALL pulse instr_done and go to FETCH0.
REQ-015 ST0 SHALL assert ACC_bus and load_MDR, then go to ST1.
REQ-016 ST1 SHALL assert CS with R_NW=0, pulse instr_done, then go to FETCH0.
REQ-017 Instruction latency SHALL be: LOAD/ADD/SUB 6 cycles, STORE 6 cycles, BNE 4 cycles, NOP 4 cycles; there SHALL be no stall inputs.
REQ-018 ALU_add and ALU_sub SHALL never both be 1, and ACC_bus, PC_bus, Addr_bus and MDR_bus SHALL be one-hot-or-zero in every cycle.
REQ-019 op and z_flag SHALL be sampled only in DECODE and EXEC; changes elsewhere SHALL have no effect.
REQ-020 Any unreachable state encoding SHALL transition to FETCH0 on the next clock with all outputs at default.

Reset
REQ-021 While reset=1 the FSM SHALL be held in FETCH0 asynchronously, with every output at its REQ-005 default (FETCH0 strobes SHALL be gated off while reset=1).
REQ-022 The first FETCH0 strobes SHALL appear in the first clock cycle after reset deasserts.
REQ-023 Reset asserted in any state, including mid-STORE at ST1, SHALL abort immediately: CS falls and R_NW returns to 1 without waiting for a clock edge.

Verification
REQ-024 Reset, then op=LOAD held -> FETCH0..EXEC sequence of 6 cycles; EXEC has MDR_bus=1, load_ACC=1, ALU_ACC=0; instr_done pulses once.
REQ-025 op=ADD, then op=SUB -> EXEC asserts ALU_add=1, ALU_sub=0, then ALU_sub=1, ALU_add=0; ALU_ACC=1 in both.
REQ-026 op=STORE -> ST0 has ACC_bus=1, load_MDR=1; ST1 has CS=1, R_NW=0; R_NW=1 in every other cycle.
REQ-027 op=BNE with z_flag=0, then op=BNE with z_flag=1 -> first DECODE has Addr_bus=1, load_PC=1; second DECODE has no strobes; each instruction takes 4 cycles.
REQ-028 op=111 -> 4-cycle NOP with no memory or ACC strobes in DECODE.
REQ-029 Reset pulsed asynchronously during ST1 -> CS=0 and R_NW=1 within the same cycle; FETCH0 strobes follow on the first edge after release.
